pc_predict_unit: RTL and testbench
==================================

# pc_predict_unit

Parametrised fetch-stage PC generator for the pipelined core. It holds the fetch PC and predicts the next fetch address from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It takes resolved branch and jump outcomes from Execute, detects mispredictions, redirects fetch, and trains the BTB. It replaces the flat PC register at the head of the Fetch stage.

## Interface
- `DATA_WIDTH`, 32: address width.
- `RESET_VECTOR`, 32'hBFC00000: pcF value after reset.
- `BTB_ENTRIES`, 16: BTB depth; power of two, ≥2; IDX_W = log2(BTB_ENTRIES).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: fetch advance enable; low = stall (hold pcF).
- `resolve_validE` in 1: a control-flow instruction resolves in Execute this cycle.
- `takenE` in 1: the resolved instruction is taken.
- `is_jumpE` in 1: the resolved instruction is JAL/JALR (unconditional).
- `pcE` in DATA_WIDTH: PC of the resolved instruction.
- `targetE` in DATA_WIDTH: computed target (branch target or JALR ALU result).
- `pred_takenE` in 1: prediction carried down the pipe with this instruction.
- `pred_targetE` in DATA_WIDTH: predicted target carried down the pipe.
- `pcF` out DATA_WIDTH: current fetch PC (registered).
- `pc_plus4F` out DATA_WIDTH: pcF + 4.
- `pred_takenF` out 1: BTB predicts taken for pcF.
- `pred_targetF` out DATA_WIDTH: predicted next PC for pcF.
- `mispredictE` out 1: flush request for the F/D/E stages.

## Operation
- **Lookup (combinational).**
  - idx = pcF[IDX_W+1:2]; tag = pcF[DATA_WIDTH-1:IDX_W+2].
  - hit = valid[idx] && tag match.
  - pred_takenF = hit && ctr[idx][1].
  - pred_targetF = pred_takenF ? btb_target[idx] : pc_plus4F.
- **Actual next PC.** actual_next = takenE ? {targetE[DATA_WIDTH-1:1],1'b0} : pcE+4. The LSB is always cleared.
- **Misprediction.**
  - mispredictE = resolve_validE && ((pred_takenE != takenE) || (takenE && pred_targetE != actual_next)).
  - mispredictE = 0 when resolve_validE = 0.
- **pcF next-state priority.**
  1. rst → RESET_VECTOR.
  2. mispredictE → actual_next. This overrides en = 0.
  3. !en → hold.
  4. Otherwise → pred_targetF.
- **BTB update** (only when resolve_validE; independent of en). Index and tag come from pcE.
  - Taken, tag hit:
    - Write target.
    - is_jumpE → ctr = STRONG_T; otherwise saturating increment.
  - Taken, miss: allocate. valid = 1, write tag and target, ctr = is_jumpE ? STRONG_T : WEAK_T. Any aliased entry is overwritten.
  - Not taken, tag hit: saturating decrement; valid stays set.
  - Not taken, miss: no change.
- **Counters.** Saturate at 2'b00 and 2'b11; no wrap.
- **Arithmetic.** All PC adds are modulo 2^DATA_WIDTH; the carry is dropped.

## Timing
- **Reset values.**
  - pcF = RESET_VECTOR.
  - All valid = 0; all ctr = WEAK_NT.
  - Outputs during and after reset: pred_takenF = 0, pred_targetF = pc_plus4F, and mispredictE follows its inputs (combinational).
- **Reset mid-operation.** Reset dominates a simultaneous mispredict and any BTB write. Training from that cycle is lost.
- **Latency.**
  - Lookup: 0 cycles (same cycle as pcF).
  - Redirect: pcF = actual_next on the edge following mispredictE.
  - BTB write: visible to lookup on the cycle after the update edge.
- **Same-index read and write in one cycle.** The lookup returns the old contents; there is no bypass.
- **BTB storage.** Flops, not SRAM, so there is no read latency.

## Configuration
- `PC_BTB_EN` defined: behaviour as above.
- `PC_BTB_EN` undefined:
  - No BTB storage.
  - pred_takenF = 0 and pred_targetF = pc_plus4F (static not-taken).
  - mispredictE = resolve_validE && takenE, whatever the pred_*E inputs are.
  - Port list unchanged.

## Structure
- **Package `pc_pred_pkg`:**
  - `ctr_t` enum: STRONG_NT = 2'b00, WEAK_NT = 2'b01, WEAK_T = 2'b10, STRONG_T = 2'b11.
  - `btb_entry_t` struct: valid, tag, target, ctr.
  - `PC_RESET_VECTOR_DEFAULT` localparam.
- **Sub-module `pc_btb`:** entry array, lookup port, update port, and the saturating counter logic. It is instantiated only under `PC_BTB_EN`.

## Test plan
All scenarios use DATA_WIDTH = 32 and BTB_ENTRIES = 16.

1. **Reset and sequential fetch.** Hold rst for 1 cycle, then en = 1 → pcF = 0xBFC00000, then 0xBFC00004, then 0xBFC00008; pred_takenF = 0 throughout.
2. **Stall.** en = 0 for 2 cycles at pcF = 0xBFC00008 → pcF held and pc_plus4F = 0xBFC0000C. Raise en → pcF = 0xBFC0000C.
3. **Cold taken branch.**
   - Stimulus: resolve pcE = 0x100, takenE = 1, targetE = 0x40, pred_takenE = 0.
   - Response: mispredictE = 1, and the next pcF = 0x40. Entry 0 holds tag 0x100 >> 6, target 0x40, WEAK_T.
   - Follow-up: drive to pcF = 0x100 → pred_takenF = 1, pred_targetF = 0x40.
4. **Decay to not-taken.** Resolve pcE = 0x100 not-taken once → ctr = WEAK_NT; pred_takenF = 0 on the next lookup of 0x100. A second not-taken → STRONG_NT; a third stays at STRONG_NT.
5. **JALR odd target while stalled.**
   - Stimulus: en = 0; resolve is_jumpE = 1, takenE = 1, targetE = 0x2001, pred_takenE = 0.
   - Response: mispredictE = 1 and the next pcF = 0x2000, despite the stall. The entry is at STRONG_T.
6. **Alias and disabled build.**
   - Alias: after scenario 3, resolve pcE = 0x140 taken to 0x80 → entry 0 is replaced, and lookup of 0x100 misses (pred_targetF = 0x104).
   - Disabled build: rebuild without `PC_BTB_EN` and rerun scenario 3 → pred_takenF = 0 at 0x100, and mispredictE = 1 on every taken resolve.

Source files
------------

// File: rtl/pc_predict_unit_pkg.sv
// -----------------------------------------------------------------------------
// pc_pred_pkg
// Shared types for the fetch-stage PC predictor: the 2-bit branch counter
// encoding, the BTB entry record, the default reset vector and the
// saturating counter helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package pc_pred_pkg;

   // Widest address the BTB entry record can hold. Tags are stored
   // zero-extended into this field; targets are stored at this width.
   localparam int PC_DATA_W = 32;

   localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } ctr_t;

   typedef struct packed {
      logic                 valid;
      logic [PC_DATA_W-1:0] tag;
      logic [PC_DATA_W-1:0] target;
      ctr_t                 ctr;
   } btb_entry_t;

   // Saturating increment: STRONG_T stays STRONG_T.
   function automatic ctr_t ctr_inc(input ctr_t c);
      case (c)
         STRONG_NT: return WEAK_NT;
         WEAK_NT:   return WEAK_T;
         WEAK_T:    return STRONG_T;
         default:   return STRONG_T;
      endcase
   endfunction

   // Saturating decrement: STRONG_NT stays STRONG_NT.
   function automatic ctr_t ctr_dec(input ctr_t c);
      case (c)
         STRONG_T: return WEAK_T;
         WEAK_T:   return WEAK_NT;
         WEAK_NT:  return STRONG_NT;
         default:  return STRONG_NT;
      endcase
   endfunction

endpackage

// File: rtl/pc_predict_unit_if.sv
// -----------------------------------------------------------------------------
// pc_predict_unit_if
// Bundle between the pipeline and the PC predictor.
//   master (pipeline side): drives en and the Execute resolve signals
//     (resolve_validE, takenE, is_jumpE, pcE, targetE, pred_takenE,
//     pred_targetE); receives pcF, pc_plus4F, pred_takenF, pred_targetF,
//     mispredictE.
//   slave (pc_predict_unit): the mirror image.
// -----------------------------------------------------------------------------
interface pc_predict_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  en;
   logic                  resolve_validE;
   logic                  takenE;
   logic                  is_jumpE;
   logic [DATA_WIDTH-1:0] pcE;
   logic [DATA_WIDTH-1:0] targetE;
   logic                  pred_takenE;
   logic [DATA_WIDTH-1:0] pred_targetE;
   logic [DATA_WIDTH-1:0] pcF;
   logic [DATA_WIDTH-1:0] pc_plus4F;
   logic                  pred_takenF;
   logic [DATA_WIDTH-1:0] pred_targetF;
   logic                  mispredictE;

   modport master (
      output en, resolve_validE, takenE, is_jumpE, pcE, targetE,
             pred_takenE, pred_targetE,
      input  pcF, pc_plus4F, pred_takenF, pred_targetF, mispredictE
   );

   modport slave (
      input  en, resolve_validE, takenE, is_jumpE, pcE, targetE,
             pred_takenE, pred_targetE,
      output pcF, pc_plus4F, pred_takenF, pred_targetF, mispredictE
   );
endinterface

// File: rtl/pc_predict_unit_btb.sv
// -----------------------------------------------------------------------------
// pc_btb
// Direct-mapped branch target buffer held in flops, with 2-bit saturating
// counters.
//   clk, rst         : clock, synchronous active-high reset
//   lookup_pc        : fetch PC to look up (combinational, no latency)
//   lookup_taken     : entry hits and its counter says taken
//   lookup_target    : stored target of the indexed entry
//   upd_valid        : a control-flow instruction resolved this cycle
//   upd_taken        : it was taken
//   upd_jump         : it was an unconditional jump
//   upd_pc           : its PC (supplies index and tag)
//   upd_target       : its LSB-cleared target
// A same-index read and write in one cycle returns the old entry.
// -----------------------------------------------------------------------------
module pc_btb
   import pc_pred_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int BTB_ENTRIES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] lookup_pc,
   output logic                  lookup_taken,
   output logic [DATA_WIDTH-1:0] lookup_target,
   input  logic                  upd_valid,
   input  logic                  upd_taken,
   input  logic                  upd_jump,
   input  logic [DATA_WIDTH-1:0] upd_pc,
   input  logic [DATA_WIDTH-1:0] upd_target
);
   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

   btb_entry_t       entries [BTB_ENTRIES];
   btb_entry_t       rd_entry;
   btb_entry_t       wr_entry;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0] rd_tag;
   logic [TAG_W-1:0] wr_tag;
   logic             wr_hit;

   // Instructions are word aligned, so the two PC LSBs never select anything.
   logic unused_lsbs;
   assign unused_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

   assign rd_idx = lookup_pc[IDX_W+1:2];
   assign rd_tag = lookup_pc[DATA_WIDTH-1:IDX_W+2];
   assign wr_idx = upd_pc[IDX_W+1:2];
   assign wr_tag = upd_pc[DATA_WIDTH-1:IDX_W+2];

   // Lookup and training-side hit detection; tags compare zero-extended.
   always_comb begin
      rd_entry      = entries[rd_idx];
      wr_entry      = entries[wr_idx];
      lookup_taken  = rd_entry.valid
                      && (rd_entry.tag == PC_DATA_W'(rd_tag))
                      && (rd_entry.ctr inside {WEAK_T, STRONG_T});
      lookup_target = DATA_WIDTH'(rd_entry.target);
      wr_hit        = wr_entry.valid && (wr_entry.tag == PC_DATA_W'(wr_tag));
   end

   // Entry array: reset clears everything, otherwise train on resolves.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            entries[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
         end
      end else if (upd_valid) begin
         if (upd_taken) begin
            if (wr_hit) begin
               entries[wr_idx].target <= PC_DATA_W'(upd_target);
               entries[wr_idx].ctr    <= upd_jump ? STRONG_T : ctr_inc(wr_entry.ctr);
            end else begin
               // Allocate; whatever aliased into this slot is lost.
               entries[wr_idx] <= '{valid:  1'b1,
                                    tag:    PC_DATA_W'(wr_tag),
                                    target: PC_DATA_W'(upd_target),
                                    ctr:    (upd_jump ? STRONG_T : WEAK_T)};
            end
         end else if (wr_hit) begin
            entries[wr_idx].ctr <= ctr_dec(wr_entry.ctr);
         end
      end
   end

endmodule

// File: rtl/pc_predict_unit.sv
// -----------------------------------------------------------------------------
// pc_predict_unit
// Fetch-stage PC generator. Holds pcF, predicts the next fetch address from
// a BTB, detects mispredictions reported by Execute and redirects fetch.
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset (pcF <= RESET_VECTOR, BTB cleared)
//   bus  : pc_predict_unit_if.slave -- en, Execute resolve inputs, and the
//          outputs pcF (registered), pc_plus4F, pred_takenF, pred_targetF,
//          mispredictE (the last three combinational)
// Build option: define PC_BTB_EN to include the BTB. Without it the unit
// predicts static not-taken and every taken resolve is a mispredict.
// -----------------------------------------------------------------------------
module pc_predict_unit
   import pc_pred_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(PC_RESET_VECTOR_DEFAULT),
   parameter int                    BTB_ENTRIES  = 16
) (
   input  logic              clk,
   input  logic              rst,
   pc_predict_unit_if.slave  bus
);
   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] pc_plus4;
   logic [DATA_WIDTH-1:0] actual_next;
   logic [DATA_WIDTH-1:0] pred_target;
   logic                  pred_taken;
   logic                  mispredict;

   // Carries out of the MSB are dropped: PC arithmetic wraps.
   assign pc_plus4    = pc_q + DATA_WIDTH'(4);
   // Jump targets can be odd (JALR); the LSB is forced to zero.
   assign actual_next = bus.takenE ? {bus.targetE[DATA_WIDTH-1:1], 1'b0}
                                   : bus.pcE + DATA_WIDTH'(4);

`ifdef PC_BTB_EN
   logic                  btb_taken;
   logic [DATA_WIDTH-1:0] btb_target;
   logic                  unused_tgt_lsb;

   assign unused_tgt_lsb = bus.targetE[0];

   pc_btb #(
      .DATA_WIDTH  (DATA_WIDTH),
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk           (clk),
      .rst           (rst),
      .lookup_pc     (pc_q),
      .lookup_taken  (btb_taken),
      .lookup_target (btb_target),
      .upd_valid     (bus.resolve_validE),
      .upd_taken     (bus.takenE),
      .upd_jump      (bus.is_jumpE),
      .upd_pc        (bus.pcE),
      .upd_target    (actual_next)
   );

   // Prediction from the BTB; mispredict compares direction and, if taken, target.
   always_comb begin
      pred_taken  = btb_taken;
      pred_target = btb_taken ? btb_target : pc_plus4;
      if (bus.resolve_validE) begin
         mispredict = (bus.pred_takenE != bus.takenE)
                      || (bus.takenE && (bus.pred_targetE != actual_next));
      end else begin
         mispredict = 1'b0;
      end
   end
`else
   // Static not-taken: the carried prediction is irrelevant.
   logic unused_pred;
   assign unused_pred = ^{bus.pred_takenE, bus.pred_targetE, bus.is_jumpE, bus.targetE[0]};

   // Static not-taken prediction; any taken resolve redirects.
   always_comb begin
      pred_taken  = 1'b0;
      pred_target = pc_plus4;
      if (bus.resolve_validE) begin
         mispredict = bus.takenE;
      end else begin
         mispredict = 1'b0;
      end
   end
`endif

   // Fetch PC: reset, then redirect (even while stalled), then stall, then predict.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_VECTOR;
      end else if (mispredict) begin
         pc_q <= actual_next;
      end else if (bus.en) begin
         pc_q <= pred_target;
      end else begin
         pc_q <= pc_q;
      end
   end

   assign bus.pcF          = pc_q;
   assign bus.pc_plus4F    = pc_plus4;
   assign bus.pred_takenF  = pred_taken;
   assign bus.pred_targetF = pred_target;
   assign bus.mispredictE  = mispredict;

endmodule

// File: tb/tb_pc_predict_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_predict_unit
// Directed bench for pc_predict_unit (DATA_WIDTH 32, 16 BTB entries).
// Expected next-PC values are queued when each step is driven and popped
// after the clock edge. Expectations adapt to whether PC_BTB_EN is defined.
// -----------------------------------------------------------------------------
module tb_pc_predict_unit;

   localparam logic [31:0] RV = 32'hBFC0_0000;
`ifdef PC_BTB_EN
   localparam bit BTB = 1'b1;
`else
   localparam bit BTB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pc_predict_unit_if #(.DATA_WIDTH(32)) bus ();

   pc_predict_unit #(
      .DATA_WIDTH   (32),
      .RESET_VECTOR (RV),
      .BTB_ENTRIES  (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, check mispredictE, then check pcF after the edge.
   task automatic step(input string tag, input logic e, input logic rv, input logic tk,
                       input logic jmp, input logic [31:0] pce, input logic [31:0] tge,
                       input logic ptk, input logic [31:0] ptg,
                       input logic exp_misp, input logic [31:0] exp_pc);
      logic [31:0] want;
      bus.en             = e;
      bus.resolve_validE = rv;
      bus.takenE         = tk;
      bus.is_jumpE       = jmp;
      bus.pcE            = pce;
      bus.targetE        = tge;
      bus.pred_takenE    = ptk;
      bus.pred_targetE   = ptg;
      #1;
      chk({tag, "/misp"}, {31'd0, bus.mispredictE}, {31'd0, exp_misp});
      exp_q.push_back(exp_pc);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s/queue: observed empty expected one entry", tag);
      end else begin
         want = exp_q.pop_front();
         chk({tag, "/pcF"}, bus.pcF, want);
         chk({tag, "/plus4"}, bus.pc_plus4F, want + 32'd4);
      end
   endtask

   // Check the combinational prediction for the current pcF.
   task automatic look(input string tag, input logic exp_tk, input logic [31:0] exp_tgt);
      chk({tag, "/pred_tk"}, {31'd0, bus.pred_takenF}, {31'd0, exp_tk});
      chk({tag, "/pred_tgt"}, bus.pred_targetF, exp_tgt);
   endtask

   // Redirect fetch to dest via a taken resolve at 0xF8 with a wrong carried target.
   task automatic goto_pc(input string tag, input logic [31:0] dest);
      step(tag, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_00F8, dest, 1'b1, 32'h0000_0200,
           1'b1, dest);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset cycle with a taken resolve presented: mispredictE still follows
      // its inputs, but reset wins for pcF and the BTB.
      rst = 1'b1;
      step("reset", 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h40, 1'b0, 32'h0, 1'b1, RV);
      look("reset", 1'b0, RV + 32'd4);
      rst = 1'b0;

      // Sequential fetch.
      step("seq1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'hBFC0_0004);
      step("seq2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'hBFC0_0008);
      look("seq2", 1'b0, 32'hBFC0_000C);

      // Stall two cycles, then advance.
      step("stall1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'hBFC0_0008);
      step("stall2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'hBFC0_0008);
      step("unstall", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'hBFC0_000C);

      // Cold taken branch 0x100 -> 0x40.
      step("cold", 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h40, 1'b0, 32'h0, 1'b1, 32'h40);
      look("at40", 1'b0, 32'h44);
      goto_pc("goto100a", 32'h100);
      look("hit100", BTB, BTB ? 32'h40 : 32'h104);

      // Decay: three not-taken resolves while stalled at 0x100.
      step("nt1", 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h100);
      look("nt1", 1'b0, 32'h104);
      step("nt2", 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h100);
      look("nt2", 1'b0, 32'h104);
      step("nt3", 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h100);
      look("nt3", 1'b0, 32'h104);

      // Taken from STRONG_NT climbs one step only: still not-taken.
      step("tk1", 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h40, 1'b1, 32'h40,
           !BTB, BTB ? 32'h100 : 32'h40);
      look("tk1", 1'b0, BTB ? 32'h104 : 32'h44);
      goto_pc("goto100b", 32'h100);
      step("tk2", 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h40, 1'b1, 32'h40,
           !BTB, BTB ? 32'h100 : 32'h40);
      look("tk2", BTB, BTB ? 32'h40 : 32'h44);

      // JALR to an odd target while stalled: redirect to 0x2000 anyway.
      step("jalr", 1'b0, 1'b1, 1'b1, 1'b1, 32'h1C4, 32'h2001, 1'b0, 32'h0, 1'b1, 32'h2000);
      look("at2000", 1'b0, 32'h2004);
      goto_pc("goto1c4", 32'h1C4);
      look("jalr_hit", BTB, BTB ? 32'h2000 : 32'h1C8);
      // One not-taken from STRONG_T still predicts taken.
      step("jalr_nt", 1'b0, 1'b1, 1'b0, 1'b0, 32'h1C4, 32'h0, 1'b0, 32'h0, 1'b0, 32'h1C4);
      look("jalr_nt", BTB, BTB ? 32'h2000 : 32'h1C8);

      // Alias: 0x140 shares entry 0 with 0x100 and replaces it.
      step("alias", 1'b1, 1'b1, 1'b1, 1'b0, 32'h140, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
      look("at80", 1'b0, 32'h84);
      goto_pc("goto100c", 32'h100);
      look("alias100", 1'b0, 32'h104);

      // No resolve: mispredictE low even with disagreeing carried prediction.
      step("norv", 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h40, 1'b0, 32'h0, 1'b0, 32'h100);

      // Reset mid-operation beats a mispredict and its BTB allocation.
      rst = 1'b1;
      step("midrst", 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h40, 1'b0, 32'h0, 1'b1, RV);
      rst = 1'b0;
      look("midrst", 1'b0, RV + 32'd4);
      goto_pc("goto100d", 32'h100);
      look("wiped100", 1'b0, 32'h104);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
